// File: rtl/multicycle_ctrl_if.sv
// Handshake/control bundle between the multicycle controller and the datapath it steers.
interface multicycle_ctrl_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ALUOP_W = 4
);
  logic [31:0]        instr;
  logic               alu_zero;
  logic               imem_ready;
  logic               dmem_ready;
  logic [ALUOP_W-1:0] alu_opcode;
  logic [1:0]         alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         imm_sel;
  logic [1:0]         result_src;
  logic               imem_req;
  logic               dmem_req;
  logic               dmem_we;
  logic               ir_write;
  logic               pc_write;
  logic               reg_write;
  logic               illegal;
  logic [XLEN-1:0]    retire_cnt;

  modport master (
    input  instr, alu_zero, imem_ready, dmem_ready,
    output alu_opcode, alu_src_a, alu_src_b, imm_sel, result_src,
           imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_write,
           illegal, retire_cnt
  );

  modport slave (
    output instr, alu_zero, imem_ready, dmem_ready,
    input  alu_opcode, alu_src_a, alu_src_b, imm_sel, result_src,
           imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_write,
           illegal, retire_cnt
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences FETCH..WRITEBACK, drives ALU opcode, mux selects,
// memory/register enables, and counts retired instructions.
module multicycle_ctrl #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ALUOP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9
  } state_e;

  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;

  localparam logic [ALUOP_W-1:0] OP_ZERO = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] OP_ADD  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] OP_SUB  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] OP_AND  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] OP_OR   = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] OP_XOR  = ALUOP_W'(5);

  state_e state_q, state_d;
  logic [XLEN-1:0] retire_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       unused_instr_bits;

  logic [ALUOP_W-1:0] r_op_c, i_op_c;
  logic               r_ok_c, i_ok_c, dec_ok_c;

  logic [ALUOP_W-1:0] alu_opcode_c;
  logic [1:0]         alu_src_a_c, alu_src_b_c, imm_sel_c, result_src_c;
  logic               imem_req_c, dmem_req_c, dmem_we_c;
  logic               ir_write_c, pc_write_c, reg_write_c, illegal_c, retire_c;

  assign opcode            = bus.instr[6:0];
  assign funct3            = bus.instr[14:12];
  assign funct7_b5         = bus.instr[30];
  assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  // Instruction field decode shared by next-state and output logic
  always_comb begin
    r_op_c   = OP_ZERO;
    i_op_c   = OP_ZERO;
    r_ok_c   = 1'b1;
    i_ok_c   = 1'b1;
    dec_ok_c = 1'b0;
    case ({funct7_b5, funct3})
      4'b0_000: r_op_c = OP_ADD;
      4'b1_000: r_op_c = OP_SUB;
      4'b0_111: r_op_c = OP_AND;
      4'b0_110: r_op_c = OP_OR;
      4'b0_100: r_op_c = OP_XOR;
      default:  r_ok_c = 1'b0;
    endcase
    case (funct3)
      3'b000:  i_op_c = OP_ADD;
      3'b111:  i_op_c = OP_AND;
      3'b110:  i_op_c = OP_OR;
      3'b100:  i_op_c = OP_XOR;
      default: i_ok_c = 1'b0;
    endcase
    case (opcode)
      OPC_LW, OPC_SW, OPC_R, OPC_I: dec_ok_c = 1'b1;
      OPC_BEQ:                      dec_ok_c = (funct3 == 3'b000);
      default:                      dec_ok_c = 1'b0;
    endcase
  end

  // State and retire counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      retire_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire_c) retire_q <= retire_q + XLEN'(1);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (bus.imem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OPC_LW, OPC_SW: state_d = S_MEMADR;
          OPC_R:          state_d = S_EXEC_R;
          OPC_I:          state_d = S_EXEC_I;
          OPC_BEQ:        state_d = (funct3 == 3'b000) ? S_BEQ : S_FETCH;
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OPC_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (bus.dmem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (bus.dmem_ready) state_d = S_FETCH;
      S_EXEC_R: state_d = r_ok_c ? S_ALUWB : S_FETCH;
      S_EXEC_I: state_d = i_ok_c ? S_ALUWB : S_FETCH;
      S_ALUWB:  state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output decode; data-memory strobes are gated by rst so an abandoned access drops at once
  always_comb begin
    alu_opcode_c = OP_ZERO;
    alu_src_a_c  = 2'd0;
    alu_src_b_c  = 2'd0;
    imm_sel_c    = 2'd0;
    result_src_c = 2'd0;
    imem_req_c   = 1'b0;
    dmem_req_c   = 1'b0;
    dmem_we_c    = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    illegal_c    = 1'b0;
    retire_c     = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_c   = 1'b1;
        alu_src_b_c  = 2'd2;
        alu_opcode_c = OP_ADD;
        result_src_c = 2'd2;
        ir_write_c   = bus.imem_ready;
        pc_write_c   = bus.imem_ready;
      end
      S_DECODE: begin
        alu_src_a_c  = 2'd1;
        alu_src_b_c  = 2'd1;
        imm_sel_c    = 2'd2;
        alu_opcode_c = OP_ADD;
        illegal_c    = ~dec_ok_c;
      end
      S_MEMADR: begin
        alu_src_a_c  = 2'd2;
        alu_src_b_c  = 2'd1;
        alu_opcode_c = OP_ADD;
        imm_sel_c    = (opcode == OPC_SW) ? 2'd1 : 2'd0;
      end
      S_MEMRD: dmem_req_c = ~rst;
      S_MEMWB: begin
        result_src_c = 2'd1;
        reg_write_c  = 1'b1;
        retire_c     = 1'b1;
      end
      S_MEMWR: begin
        dmem_req_c = ~rst;
        dmem_we_c  = ~rst;
        retire_c   = bus.dmem_ready;
      end
      S_EXEC_R: begin
        alu_src_a_c  = 2'd2;
        alu_opcode_c = r_op_c;
        illegal_c    = ~r_ok_c;
      end
      S_EXEC_I: begin
        alu_src_a_c  = 2'd2;
        alu_src_b_c  = 2'd1;
        alu_opcode_c = i_op_c;
        illegal_c    = ~i_ok_c;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
      end
      S_BEQ: begin
        alu_src_a_c  = 2'd2;
        alu_opcode_c = OP_SUB;
        pc_write_c   = bus.alu_zero;
        retire_c     = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.alu_opcode = alu_opcode_c;
  assign bus.alu_src_a  = alu_src_a_c;
  assign bus.alu_src_b  = alu_src_b_c;
  assign bus.imm_sel    = imm_sel_c;
  assign bus.result_src = result_src_c;
  assign bus.imem_req   = imem_req_c;
  assign bus.dmem_req   = dmem_req_c;
  assign bus.dmem_we    = dmem_we_c;
  assign bus.ir_write   = ir_write_c;
  assign bus.pc_write   = pc_write_c;
  assign bus.reg_write  = reg_write_c;
  assign bus.illegal    = illegal_c;
  assign bus.retire_cnt = retire_q;

endmodule
